// File: rtl/psram_qspi_if.sv
// psram_qspi_if: QSPI pins between a PSRAM controller and the device model, inout already split
interface psram_qspi_if;
  logic qspi_sck;
  logic qspi_ce_n;
  logic [3:0] dio_in;
  logic [3:0] dio_out;
  logic [3:0] dio_oe;
  modport master (output qspi_sck, qspi_ce_n, dio_in, input dio_out, dio_oe);
  modport slave (input qspi_sck, qspi_ce_n, dio_in, output dio_out, dio_oe);
endinterface

// File: rtl/psram_qspi_device.sv
// psram_qspi_device: oversampled QSPI PSRAM model decoding quad read 0xEB and quad write 0x38
module psram_qspi_device #(
  parameter int ADDR_BITS = 12,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic resetn,
  psram_qspi_if.slave bus
);
  typedef enum logic [2:0] {IGNORE, IDLE, CMD, ADDR_RD, ADDR_WR, WAIT, RDATA, WDATA} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sck_p, ce_p;
  logic [3:0] dio_p [SYNC_STAGES];
  logic sck_d, ce_d, sck_s, ce_s, rise, fall, ce_fall;
  logic [3:0] dio;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, rd;
  logic [ADDR_BITS-1:0] addr, addr_n;
  logic half, half_n, oe, oe_n, we;
  logic [3:0] out, out_n;
  logic [7:0] mem [2**ADDR_BITS];
  // synchronizers are left unreset so a reset with ce_n low does not fake a deselect
  always_ff @(posedge clk) begin
    sck_p <= {sck_p[SYNC_STAGES-2:0], bus.qspi_sck};
    ce_p <= {ce_p[SYNC_STAGES-2:0], bus.qspi_ce_n};
    dio_p[0] <= bus.dio_in;
    for (int i = 1; i < SYNC_STAGES; i++) dio_p[i] <= dio_p[i-1];
    sck_d <= sck_s;
    ce_d <= ce_s;
  end
  assign sck_s = sck_p[SYNC_STAGES-1];
  assign ce_s = ce_p[SYNC_STAGES-1];
  assign dio = dio_p[SYNC_STAGES-1];
  assign rise = sck_s & ~sck_d;
  assign fall = ~sck_s & sck_d;
  assign ce_fall = ce_d & ~ce_s;
  assign rd = mem[addr];
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IGNORE;
      cnt <= '0;
      sh <= '0;
      addr <= '0;
      half <= 1'b0;
      oe <= 1'b0;
      out <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      addr <= addr_n;
      half <= half_n;
      oe <= oe_n;
      out <= out_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    addr_n = addr;
    half_n = half;
    oe_n = oe;
    out_n = out;
    we = 1'b0;
    if (ce_s) begin
      state_n = IDLE;
      oe_n = 1'b0;
    end else case (state)
      IDLE: if (ce_fall) begin
        state_n = CMD;
        cnt_n = '0;
      end
      CMD: if (rise) begin
        sh_n = {sh[6:0], dio[0]};
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd7) state_n = sh_n == 8'hEB ? ADDR_RD : sh_n == 8'h38 ? ADDR_WR : IGNORE;
      end
      ADDR_RD, ADDR_WR: if (rise) begin
        addr_n = {addr[ADDR_BITS-5:0], dio};
        cnt_n = cnt == 3'd5 ? 3'd0 : cnt + 3'd1;
        half_n = 1'b0;
        if (cnt == 3'd5) state_n = state == ADDR_RD ? WAIT : WDATA;
      end
      WAIT: if (rise) begin
        cnt_n = cnt == 3'd5 ? 3'd0 : cnt + 3'd1;
        if (cnt == 3'd5) state_n = RDATA;
      end
      RDATA: if (fall) begin
        oe_n = 1'b1;
        out_n = half ? rd[3:0] : rd[7:4];
        half_n = ~half;
        addr_n = half ? addr + ADDR_BITS'(1) : addr;
      end
      WDATA: if (rise) begin
        half_n = ~half;
        sh_n = half ? sh : {dio, 4'h0};
        we = half;
        addr_n = half ? addr + ADDR_BITS'(1) : addr;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) if (resetn && we) mem[addr] <= {sh[7:4], dio};
  assign bus.dio_out = out;
  assign bus.dio_oe = {4{oe}};
endmodule

// File: tb/tb_psram_qspi_device.sv
// tb_psram_qspi_device: directed and random QSPI read/write traffic against a byte-array model
module tb_psram_qspi_device;
  localparam int H = 6;
  localparam int AB = 12;
  localparam int MASK = (1 << AB) - 1;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int compared = 0, mismatched = 0;
  logic [7:0] model [1 << AB];
  psram_qspi_if bus ();
  psram_qspi_device #(.ADDR_BITS(AB), .SYNC_STAGES(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] d, output logic [3:0] o, output logic [3:0] oe_r, output logic [3:0] oe_f);
    bus.dio_in = d;
    repeat (H) @(negedge clk);
    o = bus.dio_out;
    oe_r = bus.dio_oe;
    bus.qspi_sck = 1'b1;
    repeat (H) @(negedge clk);
    oe_f = bus.dio_oe;
    bus.qspi_sck = 1'b0;
  endtask

  task automatic begin_tx(input logic [7:0] cmd, input logic [23:0] a);
    logic [3:0] o, r, f, rnd;
    bus.qspi_ce_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      rnd = 4'($urandom);
      pulse({rnd[3:1], cmd[i]}, o, r, f);
    end
    for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4], o, r, f);
  endtask

  task automatic end_tx();
    repeat (H) @(negedge clk);
    bus.qspi_ce_n = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic wr_tx(input logic [23:0] a, input logic [7:0] b [$]);
    logic [3:0] o, r, f;
    begin_tx(8'h38, a);
    foreach (b[k]) begin
      pulse(b[k][7:4], o, r, f);
      chk("wr_oe", r, 4'h0);
      pulse(b[k][3:0], o, r, f);
      model[(int'(a) + k) & MASK] = b[k];
    end
    end_tx();
  endtask

  task automatic rd_body(input logic [23:0] a, input int n, input string tag);
    logic [3:0] o, r, f, hi;
    for (int i = 0; i < 6; i++) begin
      pulse(4'($urandom), o, r, f);
      chk({tag, "_wait_oe_rise"}, r, 4'h0);
      chk({tag, "_wait_oe_fall"}, f, 4'h0);
    end
    for (int k = 0; k < n; k++) begin
      pulse(4'($urandom), hi, r, f);
      chk({tag, "_oe"}, r, 4'hF);
      pulse(4'($urandom), o, r, f);
      chk({tag, "_byte"}, {hi, o}, model[(int'(a) + k) & MASK]);
    end
  endtask

  task automatic rd_tx(input logic [23:0] a, input int n, input string tag);
    begin_tx(8'hEB, a);
    rd_body(a, n, tag);
    end_tx();
  endtask

  initial begin
    logic [7:0] q [$];
    logic [3:0] o, r, f;
    logic [23:0] a;
    int n;
    bus.qspi_sck = 1'b0;
    bus.qspi_ce_n = 1'b1;
    bus.dio_in = 4'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_oe", bus.dio_oe, 4'h0);
    chk("reset_out", bus.dio_out, 4'h0);
    repeat (4) @(negedge clk);

    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    wr_tx(24'h000010, q);
    rd_tx(24'h000010, 4, "rd_dead");

    begin_tx(8'h9F, 24'($urandom));
    for (int i = 0; i < 20; i++) begin
      pulse(4'($urandom), o, r, f);
      chk("unk_oe", r | f, 4'h0);
    end
    end_tx();
    rd_tx(24'h000010, 4, "rd_after_unk");

    q = '{8'h11, 8'h22};
    wr_tx(24'h000FFF, q);
    rd_tx(24'h000000, 1, "wrap_lo");
    rd_tx(24'h000FFF, 1, "wrap_hi");
    rd_tx(24'hABCFFF, 2, "wrap_trunc");

    q = '{8'h5A, 8'hC3};
    wr_tx(24'h000020, q);
    begin_tx(8'h38, 24'h000020);
    pulse(4'hA, o, r, f);
    pulse(4'hB, o, r, f);
    pulse(4'hC, o, r, f);
    end_tx();
    model[12'h020] = 8'hAB;
    rd_tx(24'h000020, 2, "abort");

    for (int t = 0; t < 6; t++) begin
      a = 24'($urandom);
      n = int'($urandom_range(1, 4));
      q = {};
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      wr_tx(a, q);
      rd_tx(a, n, "rand");
    end

    begin_tx(8'hEB, 24'h000010);
    rd_body(24'h000010, 1, "pre_reset");
    pulse(4'h0, o, r, f);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_reset_oe", bus.dio_oe, 4'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse(4'($urandom), o, r, f);
      chk("post_reset_oe", r | f, 4'h0);
    end
    end_tx();
    rd_tx(24'h000010, 4, "rd_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/psram_qspi_device.md
Name: psram_qspi_device

Overview:
- Synthesizable QSPI PSRAM device model sitting directly downstream of the APB PSRAM controller wrapper, on its qspi_sck / qspi_ce_n / qspi_dio pins.
- Decodes the controller's quad read (0xEB) and quad write (0x38) transactions into an internal byte array.
- Oversamples the QSPI bus with the system clock; the top level splits the inout: dio_in = qspi_dio, and qspi_dio[i] = dio_oe[i] ? dio_out[i] : z.

Parameters:
- ADDR_BITS, 12, byte-array address width (array = 2^ADDR_BITS bytes); the 24-bit bus address is truncated to its low ADDR_BITS.
- SYNC_STAGES, 2, flop stages applied identically to sck, ce_n and dio_in (minimum 2).

Ports:
- clk  input  1  system clock; frequency must be at least 4x the sck frequency.
- resetn  input  1  synchronous, active-low reset.
- qspi_sck  input  1  QSPI clock from the controller.
- qspi_ce_n  input  1  chip select, active low.
- dio_in  input  4  sampled QSPI data lines.
- dio_out  output  4  driven read-data nibble.
- dio_oe  output  4  per-line output enable; all bits always equal.

Behaviour:
- Sampling: sck, ce_n and dio_in each pass through SYNC_STAGES flops so they stay mutually aligned. A rising edge (rise) or falling edge (fall) is detected from the last two synced sck values. All protocol actions below fire in the clk cycle after the detected edge.
- Reset (resetn low at a clk edge): state = IGNORE, dio_oe = 0, dio_out = 0, counters = 0. Array contents are not cleared.
- Deselect: synced ce_n high → state IDLE and dio_oe = 0 on the next clk edge, from any state. A byte with only one nibble received is discarded.
- Edge numbering: n counts rises since ce_n fell, starting at 1.
- IDLE: on synced ce_n falling, go to CMD and set the bit counter to 0.
- CMD, edges 1-8: shift dio_in[0] in, MSB first.
  - After edge 8: cmd 0xEB → ADDR_RD; cmd 0x38 → ADDR_WR; any other value → IGNORE.
- ADDR, edges 9-14: shift dio_in[3:0] in, high nibble first, forming 24 bits (bits 23:20 first). The address register takes the low ADDR_BITS.
  - After edge 14: read goes to WAIT; write goes to WDATA.
- WAIT, edges 15-20: six dummy rises; dio_oe stays 0.
- RDATA:
  - On the fall after edge 20: dio_oe = 4'hF and dio_out = mem[addr][7:4].
  - Each following fall: alternate low nibble, then the next byte's high nibble.
  - addr increments after each low nibble is presented.
  - The controller samples on rises 21, 22, ….
- WDATA, from edge 15: each rise captures dio_in.
  - First nibble → high half; second nibble → write mem[addr] and increment addr.
  - dio_oe stays 0 throughout.
- Address wrap: addr is ADDR_BITS wide and wraps from 2^ADDR_BITS-1 to 0 silently, in both read and write.
- IGNORE: no drive, no writes. Exits only to IDLE, via ce_n high.
  - Reset releasing while ce_n is low therefore ignores the in-flight transaction.
- Simultaneous ce_n rise and sck edge in the same synced sample: deselect wins and the sck edge is ignored.
- The array is a single-port byte RAM.
  - Write happens in the clk cycle after a second-nibble rise.
  - Read is combinational or registered, as long as dio_out is valid no more than 2 clk cycles after fall, which is within the half-sck-period budget at 4x ratio.
- No other commands are supported: no QPI entry (0x35), no reset-enable, no ID read.

Test Plan:
- Reset check: hold resetn = 0 for 3 clk with ce_n = 1, then release → dio_oe = 0, dio_out = 0. A following 0xEB transaction to a fresh address returns whatever the array holds (no X on outputs in the initialized-array build).
- Write/read: 0x38 at 0x000010 with bytes DE AD BE EF, ce_n high, then 0xEB at 0x000010 for 4 bytes.
  - Nibbles D,E,A,D,B,E,E,F are presented on rises 21-28.
  - dio_oe first rises after the fall following rise 20.
- Unknown command: 0x9F followed by 20 sck cycles with random dio → dio_oe never asserts; a readback of 0x000010 still returns DE AD BE EF.
- Wrap: with ADDR_BITS = 12, write 11 22 at 0x000FFF, then read 1 byte at 0x000000 → 0x22. Reading 1 byte at 0x000FFF → 0x11.
- Aborted write: 0x38 at 0x000020 with 3 nibbles A,B,C, then ce_n high. mem[0x20] = 0xAB; mem[0x21] keeps its prior value.
- Reset mid-read: assert resetn low during the RDATA phase → dio_oe = 0 on the next clk edge. After release with ce_n still low, no drive; after ce_n toggles high then low, a new 0xEB read works normally.
